// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller.
// Drives the PC, IF_ID and ID_EX stall/flush controls. It resolves load-use
// hazards, taken-branch/jump redirects, instruction-fetch wait states and
// multi-cycle MDU occupancy. It also counts stalled cycles for profiling.
//
// Ports
//   clk, rst_n          clock; asynchronous active-low reset
//   id_rs, id_rt        source fields of the instruction in ID
//   id_uses_rt          the ID instruction reads Rt
//   id_jump             the ID instruction is a jump
//   id_mdu_start        the ID instruction starts the MDU
//   ex_mem_read, ex_rt  a load is in EX, and its destination register
//   ex_branch_taken     a branch resolved taken in EX
//   imem_ready          instruction memory delivers a word this cycle
//   stat_clr            synchronous clear of stall_cycles
//   pc_stall            hold the PC
//   if_id_stall         hold IF_ID
//   if_id_flush         load a NOP into IF_ID
//   id_ex_flush         load a bubble into ID_EX
//   mdu_busy            the FSM is in MDU_BUSY (exposes the FSM state)
//   stall_cycles        saturating count of cycles with pc_stall=1
//
// Handshake: the outputs are combinational from the state and the current
// inputs. The pipeline registers sample them on the same rising edge, so the
// response latency is zero cycles.
module hazard_ctrl #(
  parameter int MDU_CYCLES = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             id_jump,
  input  logic             id_mdu_start,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rt,
  input  logic             ex_branch_taken,
  input  logic             imem_ready,
  input  logic             stat_clr,
  output logic             pc_stall,
  output logic             if_id_stall,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             mdu_busy,
  output logic [CNT_W-1:0] stall_cycles
);

  typedef enum logic {
    S_RUN      = 1'b0,
    S_MDU_BUSY = 1'b1
  } state_t;

  // The start cycle is not counted, and the last busy cycle runs at count 0.
  localparam logic [7:0] MDU_LOAD = 8'(MDU_CYCLES - 2);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [7:0]       r_mdu_cnt;
  logic [7:0]       w_mdu_cnt_nxt;
  logic [CNT_W-1:0] r_stall_cycles;

  logic w_load_use;
  logic w_pc_stall;
  logic w_if_id_stall;
  logic w_if_id_flush;
  logic w_id_ex_flush;

  assign w_load_use = ex_mem_read && (ex_rt != 5'd0) &&
                      ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

  always_comb begin
    w_state_nxt   = r_state;
    w_mdu_cnt_nxt = r_mdu_cnt;
    w_pc_stall    = 1'b0;
    w_if_id_stall = 1'b0;
    w_if_id_flush = 1'b0;
    w_id_ex_flush = 1'b0;
    case (r_state)
      S_RUN: begin
        if (ex_branch_taken) begin
          w_if_id_flush = 1'b1;
          w_id_ex_flush = 1'b1;
        end else if (w_load_use) begin
          // A start that is held in ID by the bubble starts again next cycle.
          w_pc_stall    = 1'b1;
          w_if_id_stall = 1'b1;
          w_id_ex_flush = 1'b1;
        end else begin
          if (!imem_ready || id_jump) begin
            w_if_id_flush = 1'b1;
            w_pc_stall    = !imem_ready;
          end
          // The MDU instruction leaves ID even during a fetch wait or a jump.
          if (id_mdu_start) begin
            w_state_nxt   = S_MDU_BUSY;
            w_mdu_cnt_nxt = MDU_LOAD;
          end
        end
      end
      S_MDU_BUSY: begin
        if (ex_branch_taken) begin
          // A branch here is a protocol violation. The redirect outputs win,
          // and the MDU count keeps running.
          w_if_id_flush = 1'b1;
          w_id_ex_flush = 1'b1;
        end else begin
          w_pc_stall    = 1'b1;
          w_if_id_stall = 1'b1;
          w_id_ex_flush = 1'b1;
        end
        if (r_mdu_cnt == 8'd0) begin
          w_state_nxt = S_RUN;
        end else begin
          w_mdu_cnt_nxt = r_mdu_cnt - 8'd1;
        end
      end
      default: begin
        w_state_nxt = S_RUN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_RUN;
      r_mdu_cnt <= 8'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_mdu_cnt <= w_mdu_cnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cycles <= '0;
    end else if (stat_clr) begin
      r_stall_cycles <= '0;
    end else if (w_pc_stall && (r_stall_cycles != {CNT_W{1'b1}})) begin
      r_stall_cycles <= r_stall_cycles + CNT_W'(1);
    end
  end

  // The controls depend on live inputs. Gating them with rst_n forces them
  // to read zero for the whole reset window.
  assign pc_stall     = w_pc_stall    & rst_n;
  assign if_id_stall  = w_if_id_stall & rst_n;
  assign if_id_flush  = w_if_id_flush & rst_n;
  assign id_ex_flush  = w_id_ex_flush & rst_n;
  assign mdu_busy     = (r_state == S_MDU_BUSY);
  assign stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;
  localparam int MDU_CYCLES = 4;
  localparam int CNT_W      = 4;
  localparam int CNT_MAX    = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [4:0]       id_rs, id_rt, ex_rt;
  logic             id_uses_rt, id_jump, id_mdu_start, ex_mem_read;
  logic             ex_branch_taken, imem_ready, stat_clr;
  logic             pc_stall, if_id_stall, if_id_flush, id_ex_flush, mdu_busy;
  logic [CNT_W-1:0] stall_cycles;

  int n_vec = 0;
  int n_err = 0;
  // Reference model: remaining MDU stall cycles (0 = running) and stall count.
  int busy_left = 0;
  int stalls = 0;

  hazard_ctrl #(.MDU_CYCLES(MDU_CYCLES), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt), .id_jump(id_jump),
    .id_mdu_start(id_mdu_start), .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
    .ex_branch_taken(ex_branch_taken), .imem_ready(imem_ready), .stat_clr(stat_clr),
    .pc_stall(pc_stall), .if_id_stall(if_id_stall), .if_id_flush(if_id_flush),
    .id_ex_flush(id_ex_flush), .mdu_busy(mdu_busy), .stall_cycles(stall_cycles)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_idle();
    id_rs = 5'd0; id_rt = 5'd0; ex_rt = 5'd0;
    id_uses_rt = 1'b0; id_jump = 1'b0; id_mdu_start = 1'b0; ex_mem_read = 1'b0;
    ex_branch_taken = 1'b0; imem_ready = 1'b1; stat_clr = 1'b0;
  endtask

  task automatic set_load_use();
    ex_mem_read = 1'b1; ex_rt = 5'd8; id_rs = 5'd8;
  endtask

  // Inputs are set just after a rising edge. Outputs are checked at the
  // falling edge, and the model advances after the next rising edge.
  task automatic cycle(input string tag);
    logic e_pcs, e_ifs, e_iff, e_idf, lu;
    int nb, ns;
    @(negedge clk);
    lu = ex_mem_read && (ex_rt != 0) &&
         ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
    e_pcs = 0; e_ifs = 0; e_iff = 0; e_idf = 0;
    nb = busy_left; ns = stalls;
    if (!rst_n) begin
      nb = 0; ns = 0;
    end else begin
      if (busy_left > 0) begin
        nb = busy_left - 1;
        if (ex_branch_taken) begin e_iff = 1; e_idf = 1; end
        else begin e_pcs = 1; e_ifs = 1; e_idf = 1; end
      end else if (ex_branch_taken) begin
        e_iff = 1; e_idf = 1;
      end else if (lu) begin
        e_pcs = 1; e_ifs = 1; e_idf = 1;
      end else begin
        if (!imem_ready || id_jump) begin e_iff = 1; e_pcs = !imem_ready; end
        if (id_mdu_start) nb = MDU_CYCLES - 1;
      end
      if (stat_clr) ns = 0;
      else if (e_pcs && stalls < CNT_MAX) ns = stalls + 1;
    end
    chk({tag, ".pc_stall"},    16'(pc_stall),     16'(e_pcs));
    chk({tag, ".if_id_stall"}, 16'(if_id_stall),  16'(e_ifs));
    chk({tag, ".if_id_flush"}, 16'(if_id_flush),  16'(e_iff));
    chk({tag, ".id_ex_flush"}, 16'(id_ex_flush),  16'(e_idf));
    chk({tag, ".mdu_busy"},    16'(mdu_busy),     16'(busy_left > 0));
    chk({tag, ".stall_cyc"},   16'(stall_cycles), 16'(stalls));
    chk({tag, ".excl"},        16'(if_id_stall & if_id_flush), 16'(0));
    @(posedge clk);
    #1;
    busy_left = nb;
    stalls = ns;
  endtask

  initial begin
    set_idle();
    rst_n = 1'b0;
    cycle("reset");
    cycle("reset");
    rst_n = 1'b1;
    cycle("idle");

    // T1: load-use on Rs stalls exactly one cycle. The Rt path needs id_uses_rt. r0 never hazards.
    set_load_use();
    cycle("t1_lu");
    set_idle();
    cycle("t1_after");
    chk("t1_cnt", 16'(stall_cycles), 16'(1));
    ex_mem_read = 1'b1; ex_rt = 5'd0; id_rs = 5'd0;
    cycle("t1_r0");
    set_idle();
    ex_mem_read = 1'b1; ex_rt = 5'd9; id_rt = 5'd9; id_rs = 5'd3; id_uses_rt = 1'b1;
    cycle("t1_rt");
    id_uses_rt = 1'b0;
    cycle("t1_rt_unused");

    // T2: a taken branch beats load-use.
    set_idle();
    set_load_use();
    ex_branch_taken = 1'b1;
    cycle("t2_br");

    // T3: an MDU start gives three busy stall cycles.
    set_idle();
    stat_clr = 1'b1;
    cycle("t3_clr");
    stat_clr = 1'b0;
    id_mdu_start = 1'b1;
    cycle("t3_start");
    set_idle();
    repeat (3) cycle("t3_busy");
    cycle("t3_run");
    chk("t3_cnt", 16'(stall_cycles), 16'(3));

    // T4: fetch wait, then a jump alone, then a start during a fetch wait.
    imem_ready = 1'b0;
    repeat (5) cycle("t4_wait");
    set_idle();
    id_jump = 1'b1;
    cycle("t4_jump");
    set_idle();
    imem_ready = 1'b0; id_mdu_start = 1'b1;
    cycle("t4_wait_start");
    set_idle();
    repeat (4) cycle("t4_busy");

    // T5: reset on the second busy cycle.
    id_mdu_start = 1'b1;
    cycle("t5_start");
    set_idle();
    cycle("t5_busy1");
    set_load_use();
    #2;
    rst_n = 1'b0;
    busy_left = 0; stalls = 0;
    #1;
    chk("t5_pc_stall", 16'(pc_stall), 16'(0));
    chk("t5_if_id_stall", 16'(if_id_stall), 16'(0));
    chk("t5_id_ex_flush", 16'(id_ex_flush), 16'(0));
    chk("t5_mdu_busy", 16'(mdu_busy), 16'(0));
    chk("t5_cnt", 16'(stall_cycles), 16'(0));
    @(posedge clk);
    #1;
    cycle("t5_inrst");
    rst_n = 1'b1;
    set_idle();
    cycle("t5_run");

    // T6: saturation at 15, then stat_clr during a stall.
    set_load_use();
    repeat (20) cycle("t6_sat");
    chk("t6_sat15", 16'(stall_cycles), 16'(15));
    stat_clr = 1'b1;
    cycle("t6_clr");
    stat_clr = 1'b0;
    chk("t6_cleared", 16'(stall_cycles), 16'(0));
    cycle("t6_restart");

    // Random mix against the model.
    set_idle();
    repeat (400) begin
      id_rs           = 5'($urandom_range(0, 3));
      id_rt           = 5'($urandom_range(0, 3));
      ex_rt           = 5'($urandom_range(0, 3));
      id_uses_rt      = ($urandom_range(0, 1) == 0);
      ex_mem_read     = ($urandom_range(0, 2) == 0);
      ex_branch_taken = ($urandom_range(0, 9) == 0);
      imem_ready      = ($urandom_range(0, 4) != 0);
      id_jump         = ($urandom_range(0, 7) == 0);
      id_mdu_start    = ($urandom_range(0, 7) == 0);
      stat_clr        = ($urandom_range(0, 19) == 0);
      cycle("rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
